// File: rtl/camera_mode_pkg.sv
// Shared types and helpers for the capture-path mode selector.
// No logic of its own; holds the FSM state encoding and default timing constants.
// Slice helpers map a mode index onto its lane of a flattened per-mode bus.
package camera_mode_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT_FRAME = 2'd1,
        CAM_RST    = 2'd2,
        WAIT_SYNC  = 2'd3
    } cms_state_e;

    localparam int RST_CYC_DEF = 8;
    localparam int SYNC_TO_DEF = 1 << 20;

    // Low bit of lane idx in a bus of w-bit lanes.
    function automatic int cfg_lo(input int idx, input int w);
        return idx * w;
    endfunction

    // A mode index is usable only when it names an existing source.
    function automatic logic mode_ok(input int mode, input int num_modes);
        return mode < num_modes;
    endfunction

endpackage

// File: rtl/cam_rst_pulse.sv
// Camera re-init pulse: drives rstn low for RST_CYC cycles after a start strobe.
// Latency: rstn falls the cycle after start; done strobes in the last low cycle.
// No backpressure; a start while already active restarts the pulse.
module cam_rst_pulse
    import camera_mode_pkg::*;
#(
    parameter int RST_CYC = RST_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic rstn,
    output logic done
);

    localparam int CW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          rstn_q, rstn_d;

    // Count the low phase; release and flag done on its final cycle.
    always_comb begin
        cnt_d  = cnt_q;
        rstn_d = rstn_q;
        done   = 1'b0;
        if (start) begin
            rstn_d = 1'b0;
            cnt_d  = '0;
        end else if (!rstn_q) begin
            if (cnt_q == CW'(RST_CYC - 1)) begin
                rstn_d = 1'b1;
                done   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Pulse state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            rstn_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            rstn_q <= rstn_d;
        end
    end

    assign rstn = rstn_q;

endmodule

// File: rtl/camera_mode_switch.sv
// Frame-aligned mode selector muxing N pixel sources onto the SDRAM write port.
// Latency: 1 cycle src_en/src_data -> sdram_wren/wrdata; geometry follows cur_mode.
// No backpressure; writes are suppressed while the camera re-initialises.
module camera_mode_switch
    import camera_mode_pkg::*;
#(
    parameter int NUM_MODES = 4,
    parameter int DATA_W    = 16,
    parameter int PIX_W     = 11,
    parameter int RST_CYC   = RST_CYC_DEF,
    parameter int SYNC_TO   = SYNC_TO_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    input  logic [$clog2(NUM_MODES)-1:0]   req_mode,
    input  logic                           frame_start,
    input  logic [NUM_MODES-1:0]           src_en,
    input  logic [NUM_MODES*DATA_W-1:0]    src_data,
    input  logic [NUM_MODES*PIX_W-1:0]     cfg_h,
    input  logic [NUM_MODES*PIX_W-1:0]     cfg_v,
    input  logic [NUM_MODES*16-1:0]        cfg_x,
    input  logic [NUM_MODES*16-1:0]        cfg_y,
    output logic                           sdram_wren,
    output logic [DATA_W-1:0]              sdram_wrdata,
    output logic [PIX_W-1:0]               h_pixel,
    output logic [PIX_W-1:0]               v_pixel,
    output logic                           camera_rstn,
    output logic [15:0]                    x_lenth,
    output logic [15:0]                    y_lenth,
    output logic [$clog2(NUM_MODES)-1:0]   cur_mode,
    output logic                           busy,
    output logic                           sync_timeout
);

    localparam int MODE_W = $clog2(NUM_MODES);
    localparam int SCW    = (SYNC_TO > 1) ? $clog2(SYNC_TO) : 1;

    cms_state_e        state_q, state_d;
    logic [MODE_W-1:0] cur_mode_q, cur_mode_d;
    logic [MODE_W-1:0] tgt_mode_q, tgt_mode_d;
    logic              pend_vld_q, pend_vld_d;
    logic [MODE_W-1:0] pend_mode_q, pend_mode_d;
    logic [15:0]       x_q, x_d, y_q, y_d;
    logic [SCW-1:0]    sync_cnt_q, sync_cnt_d;
    logic              sync_timeout_q, sync_timeout_d;
    logic              wren_q, wren_d;
    logic [DATA_W-1:0] wrdata_q, wrdata_d;

    logic              req_ok;
    logic [MODE_W-1:0] tgt_now;
    logic              pend_now_vld;
    logic [MODE_W-1:0] pend_now_mode;
    logic              exit_sync;
    logic              rst_start;
    logic              rst_done;
    logic              wr_block;

    cam_rst_pulse #(
        .RST_CYC (RST_CYC)
    ) u_rst_pulse (
        .clk   (clk),
        .rst_n (rst_n),
        .start (rst_start),
        .rstn  (camera_rstn),
        .done  (rst_done)
    );

    // Mode-switch FSM: request handling, frame alignment, pending replay.
    always_comb begin
        state_d        = state_q;
        cur_mode_d     = cur_mode_q;
        tgt_mode_d     = tgt_mode_q;
        pend_vld_d     = pend_vld_q;
        pend_mode_d    = pend_mode_q;
        x_d            = x_q;
        y_d            = y_q;
        sync_cnt_d     = sync_cnt_q;
        sync_timeout_d = 1'b0;
        rst_start      = 1'b0;
        wr_block       = 1'b0;
        exit_sync      = 1'b0;
        req_ok         = req_valid && mode_ok(int'(req_mode), NUM_MODES);
        tgt_now        = req_ok ? req_mode : tgt_mode_q;
        // Last request wins while the switch cannot take it directly.
        pend_now_vld   = pend_vld_q || req_ok;
        pend_now_mode  = req_ok ? req_mode : pend_mode_q;

        case (state_q)
            RUN: begin
                if (req_ok && (req_mode != cur_mode_q)) begin
                    tgt_mode_d = req_mode;
                    state_d    = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                tgt_mode_d = tgt_now;
                if (tgt_now == cur_mode_q) begin
                    state_d = RUN;
                end else if (frame_start) begin
                    cur_mode_d = tgt_now;
                    x_d        = cfg_x[cfg_lo(int'(tgt_now), 16) +: 16];
                    y_d        = cfg_y[cfg_lo(int'(tgt_now), 16) +: 16];
                    rst_start  = 1'b1;
                    wr_block   = 1'b1;
                    state_d    = CAM_RST;
                end
            end
            CAM_RST: begin
                pend_vld_d  = pend_now_vld;
                pend_mode_d = pend_now_mode;
                sync_cnt_d  = '0;
                if (rst_done) begin
                    state_d = WAIT_SYNC;
                end
            end
            WAIT_SYNC: begin
                if (frame_start) begin
                    exit_sync = 1'b1;
                end else if (sync_cnt_q == SCW'(SYNC_TO - 1)) begin
                    exit_sync      = 1'b1;
                    sync_timeout_d = 1'b1;
                end else begin
                    sync_cnt_d = sync_cnt_q + 1'b1;
                end
                if (exit_sync) begin
                    state_d    = RUN;
                    pend_vld_d = 1'b0;
                    // A stored request is replayed as a fresh RUN request.
                    if (pend_now_vld && (pend_now_mode != cur_mode_q)) begin
                        tgt_mode_d = pend_now_mode;
                        state_d    = WAIT_FRAME;
                    end
                end else begin
                    pend_vld_d  = pend_now_vld;
                    pend_mode_d = pend_now_mode;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Write mux: forward the active source unless the camera is re-syncing.
    always_comb begin
        wren_d   = 1'b0;
        wrdata_d = wrdata_q;
        if (((state_q == RUN) || (state_q == WAIT_FRAME)) && !wr_block) begin
            wren_d = src_en[cur_mode_q];
            if (src_en[cur_mode_q]) begin
                wrdata_d = src_data[cfg_lo(int'(cur_mode_q), DATA_W) +: DATA_W];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= RUN;
            cur_mode_q     <= '0;
            tgt_mode_q     <= '0;
            pend_vld_q     <= 1'b0;
            pend_mode_q    <= '0;
            x_q            <= cfg_x[15:0];
            y_q            <= cfg_y[15:0];
            sync_cnt_q     <= '0;
            sync_timeout_q <= 1'b0;
            wren_q         <= 1'b0;
            wrdata_q       <= '0;
        end else begin
            state_q        <= state_d;
            cur_mode_q     <= cur_mode_d;
            tgt_mode_q     <= tgt_mode_d;
            pend_vld_q     <= pend_vld_d;
            pend_mode_q    <= pend_mode_d;
            x_q            <= x_d;
            y_q            <= y_d;
            sync_cnt_q     <= sync_cnt_d;
            sync_timeout_q <= sync_timeout_d;
            wren_q         <= wren_d;
            wrdata_q       <= wrdata_d;
        end
    end

    assign sdram_wren   = wren_q;
    assign sdram_wrdata = wrdata_q;
    assign h_pixel      = cfg_h[cfg_lo(int'(cur_mode_q), PIX_W) +: PIX_W];
    assign v_pixel      = cfg_v[cfg_lo(int'(cur_mode_q), PIX_W) +: PIX_W];
    assign x_lenth      = x_q;
    assign y_lenth      = y_q;
    assign cur_mode     = cur_mode_q;
    assign busy         = (state_q != RUN);
    assign sync_timeout = sync_timeout_q;

endmodule

// File: tb/tb_camera_mode_switch.sv
// Directed bench for camera_mode_switch with hand-computed expectations.
// Inputs change 1 time unit after each rising edge; outputs are read there too.
// Every wait on the DUT is bounded by a cycle budget.
module tb_camera_mode_switch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [1:0]  req_mode;
    logic        frame_start;
    logic [3:0]  src_en;
    logic [63:0] src_data;
    logic [43:0] cfg_h, cfg_v;
    logic [63:0] cfg_x, cfg_y;
    logic        sdram_wren;
    logic [15:0] sdram_wrdata;
    logic [10:0] h_pixel, v_pixel;
    logic        camera_rstn;
    logic [15:0] x_lenth, y_lenth;
    logic [1:0]  cur_mode;
    logic        busy;
    logic        sync_timeout;

    logic [7:0]  seq;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    // Source i carries {i+1, 0, seq} so the selected lane is identifiable.
    always_comb begin
        src_data = '0;
        for (int i = 0; i < 4; i++) src_data[i*16 +: 16] = {4'(i + 1), 4'h0, seq};
    end

    camera_mode_switch #(
        .NUM_MODES (4),
        .DATA_W    (16),
        .PIX_W     (11),
        .RST_CYC   (8),
        .SYNC_TO   (100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_mode     (req_mode),
        .frame_start  (frame_start),
        .src_en       (src_en),
        .src_data     (src_data),
        .cfg_h        (cfg_h),
        .cfg_v        (cfg_v),
        .cfg_x        (cfg_x),
        .cfg_y        (cfg_y),
        .sdram_wren   (sdram_wren),
        .sdram_wrdata (sdram_wrdata),
        .h_pixel      (h_pixel),
        .v_pixel      (v_pixel),
        .camera_rstn  (camera_rstn),
        .x_lenth      (x_lenth),
        .y_lenth      (y_lenth),
        .cur_mode     (cur_mode),
        .busy         (busy),
        .sync_timeout (sync_timeout)
    );

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until camera_rstn is high again; returns low cycles seen.
    task automatic wait_rstn_high(output int lows);
        lows = 0;
        while (camera_rstn === 1'b0 && lows < 40) begin
            lows++;
            step(1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_mode = 2'd0; frame_start = 1'b0;
        src_en = 4'b0001; seq = 8'h55;
        step(2);
        n_vec++; if (cur_mode !== 2'd0) begin n_bad++; $display("FAIL reset_cur_mode got %0h exp 0", cur_mode); end
        n_vec++; if (x_lenth !== 16'h5a40) begin n_bad++; $display("FAIL reset_x_lenth got %h exp 5a40", x_lenth); end
        n_vec++; if (y_lenth !== 16'h0f00) begin n_bad++; $display("FAIL reset_y_lenth got %h exp 0f00", y_lenth); end
        n_vec++; if (camera_rstn !== 1'b1) begin n_bad++; $display("FAIL reset_camera_rstn got %b exp 1", camera_rstn); end
        n_vec++; if (sdram_wren !== 1'b0) begin n_bad++; $display("FAIL reset_wren got %b exp 0", sdram_wren); end
        n_vec++; if (sdram_wrdata !== 16'h0000) begin n_bad++; $display("FAIL reset_wrdata got %h exp 0000", sdram_wrdata); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_vec++; if (sync_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_sync_timeout got %b exp 0", sync_timeout); end
        n_vec++; if (h_pixel !== 11'd640 || v_pixel !== 11'd480) begin n_bad++; $display("FAIL reset_geom got %0d x %0d exp 640 x 480", h_pixel, v_pixel); end
        rst_n = 1'b1; src_en = 4'b0000;
        step(1);
    endtask

    task automatic test_stream();
        src_en = 4'b0001; seq = 8'h11;
        step(1);
        n_vec++; if (sdram_wren !== 1'b1 || sdram_wrdata !== 16'h1011) begin n_bad++; $display("FAIL stream_src0 got %b/%h exp 1/1011", sdram_wren, sdram_wrdata); end
        src_en = 4'b0010; seq = 8'h22;
        step(1);
        n_vec++; if (sdram_wren !== 1'b0 || sdram_wrdata !== 16'h1011) begin n_bad++; $display("FAIL stream_unselected got %b/%h exp 0/1011", sdram_wren, sdram_wrdata); end
        src_en = 4'b0000;
        step(1);
    endtask

    task automatic test_switch();
        int lows;
        req_valid = 1'b1; req_mode = 2'd2; src_en = 4'b0001; seq = 8'h30;
        step(1);
        req_valid = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL switch_busy got %b exp 1", busy); end
        n_vec++; if (sdram_wren !== 1'b1 || sdram_wrdata !== 16'h1030) begin n_bad++; $display("FAIL switch_stream_t1 got %b/%h exp 1/1030", sdram_wren, sdram_wrdata); end
        for (int k = 1; k < 10; k++) begin
            seq = 8'h30 + 8'(k);
            step(1);
        end
        n_vec++; if (cur_mode !== 2'd0 || sdram_wrdata !== 16'h1039) begin n_bad++; $display("FAIL switch_wait_frame got mode %0d data %h exp 0/1039", cur_mode, sdram_wrdata); end
        frame_start = 1'b1; seq = 8'h3a;
        step(1);
        frame_start = 1'b0; src_en = 4'b0100;
        n_vec++; if (cur_mode !== 2'd2) begin n_bad++; $display("FAIL switch_cur_mode got %0d exp 2", cur_mode); end
        n_vec++; if (x_lenth !== 16'h3c20 || y_lenth !== 16'h0f22) begin n_bad++; $display("FAIL switch_xy got %h/%h exp 3c20/0f22", x_lenth, y_lenth); end
        n_vec++; if (h_pixel !== 11'd800 || v_pixel !== 11'd600) begin n_bad++; $display("FAIL switch_geom got %0d x %0d exp 800 x 600", h_pixel, v_pixel); end
        n_vec++; if (sdram_wren !== 1'b0 || sdram_wrdata !== 16'h1039) begin n_bad++; $display("FAIL switch_frame_blocked got %b/%h exp 0/1039", sdram_wren, sdram_wrdata); end
        // Count the low phase; raise frame_start in its last cycle, which must be ignored.
        lows = 0;
        while (camera_rstn === 1'b0 && lows < 40) begin
            lows++;
            frame_start = (lows == 8);
            step(1);
        end
        frame_start = 1'b0;
        n_vec++; if (lows != 8) begin n_bad++; $display("FAIL switch_rst_width got %0d exp 8", lows); end
        n_vec++; if (busy !== 1'b1 || sdram_wren !== 1'b0) begin n_bad++; $display("FAIL switch_edge_fs_ignored got busy %b wren %b exp 1/0", busy, sdram_wren); end
        step(2);
        n_vec++; if (sdram_wren !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL switch_sync_blocked got wren %b busy %b exp 0/1", sdram_wren, busy); end
        frame_start = 1'b1; seq = 8'h40;
        step(1);
        frame_start = 1'b0; seq = 8'h41;
        n_vec++; if (busy !== 1'b0 || sdram_wren !== 1'b0) begin n_bad++; $display("FAIL switch_sync_exit got busy %b wren %b exp 0/0", busy, sdram_wren); end
        step(1);
        n_vec++; if (sdram_wren !== 1'b1 || sdram_wrdata !== 16'h3041) begin n_bad++; $display("FAIL switch_stream_src2 got %b/%h exp 1/3041", sdram_wren, sdram_wrdata); end
        src_en = 4'b0000;
        step(1);
    endtask

    task automatic test_pending_timeout();
        int lows;
        int n;
        req_valid = 1'b1; req_mode = 2'd0;
        step(1);
        req_valid = 1'b0;
        step(2);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        n_vec++; if (cur_mode !== 2'd0 || camera_rstn !== 1'b0) begin n_bad++; $display("FAIL pend_first_switch got mode %0d rstn %b exp 0/0", cur_mode, camera_rstn); end
        req_valid = 1'b1; req_mode = 2'd1;
        step(1);
        req_mode = 2'd3;
        step(1);
        req_valid = 1'b0;
        wait_rstn_high(lows);
        step(1);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        n_vec++; if (busy !== 1'b1 || cur_mode !== 2'd0) begin n_bad++; $display("FAIL pend_replay got busy %b mode %0d exp 1/0", busy, cur_mode); end
        step(2);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        n_vec++; if (cur_mode !== 2'd3 || x_lenth !== 16'h1e00) begin n_bad++; $display("FAIL pend_last_wins got mode %0d x %h exp 3/1e00", cur_mode, x_lenth); end
        wait_rstn_high(lows);
        n = 0;
        while (sync_timeout !== 1'b1 && n < 300) begin
            step(1);
            n++;
        end
        n_vec++; if (n != 100) begin n_bad++; $display("FAIL timeout_delay got %0d exp 100", n); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout_run got busy %b exp 0", busy); end
        step(1);
        n_vec++; if (sync_timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_one_cycle got %b exp 0", sync_timeout); end
    endtask

    task automatic test_ignore();
        req_valid = 1'b1; req_mode = 2'd3;
        step(1);
        req_valid = 1'b0;
        n_vec++; if (busy !== 1'b0 || cur_mode !== 2'd3) begin n_bad++; $display("FAIL ignore_same got busy %b mode %0d exp 0/3", busy, cur_mode); end
        req_valid = 1'b1; req_mode = 2'd1;
        step(1);
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ignore_wf_enter got busy %b exp 1", busy); end
        req_mode = 2'd3;
        step(1);
        req_valid = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_cancel got busy %b exp 0", busy); end
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        n_vec++; if (cur_mode !== 2'd3 || camera_rstn !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL ignore_no_switch got mode %0d rstn %b busy %b exp 3/1/0", cur_mode, camera_rstn, busy); end
    endtask

    task automatic test_same_cycle();
        int lows;
        req_valid = 1'b1; req_mode = 2'd0;
        step(1);
        req_valid = 1'b0;
        step(1);
        frame_start = 1'b1; req_valid = 1'b1; req_mode = 2'd1;
        step(1);
        frame_start = 1'b0; req_valid = 1'b0;
        n_vec++; if (cur_mode !== 2'd1 || x_lenth !== 16'h2810 || h_pixel !== 11'd320) begin n_bad++; $display("FAIL same_cycle got mode %0d x %h h %0d exp 1/2810/320", cur_mode, x_lenth, h_pixel); end
        wait_rstn_high(lows);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL same_cycle_done got busy %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_mode = 2'd2;
        step(1);
        req_valid = 1'b0; frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        step(2);
        req_valid = 1'b1; req_mode = 2'd3;
        step(1);
        req_valid = 1'b0;
        n_vec++; if (camera_rstn !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL midrst_pre got rstn %b busy %b exp 0/1", camera_rstn, busy); end
        rst_n = 1'b0;
        step(1);
        n_vec++; if (camera_rstn !== 1'b1 || cur_mode !== 2'd0 || busy !== 1'b0 || x_lenth !== 16'h5a40) begin
            n_bad++; $display("FAIL midrst_state got rstn %b mode %0d busy %b x %h exp 1/0/0/5a40", camera_rstn, cur_mode, busy, x_lenth);
        end
        rst_n = 1'b1;
        step(20);
        n_vec++; if (busy !== 1'b0 || cur_mode !== 2'd0) begin n_bad++; $display("FAIL midrst_pending_lost got busy %b mode %0d exp 0/0", busy, cur_mode); end
    endtask

    initial begin
        cfg_x = {16'h1e00, 16'h3c20, 16'h2810, 16'h5a40};
        cfg_y = {16'h0f33, 16'h0f22, 16'h0f11, 16'h0f00};
        cfg_h = {11'd1024, 11'd800, 11'd320, 11'd640};
        cfg_v = {11'd768, 11'd600, 11'd240, 11'd480};
        test_reset();
        test_stream();
        test_switch();
        test_pending_timeout();
        test_ignore();
        test_same_cycle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
